regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of the 4x8 register file and shares it between ALU/MOV writeback and load writeback.

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
//==============================================================================
// regfile_wb_arbiter: round-robin owner of the register file write port, with a load scoreboard.
// Rev 1.0 -- optional statistics counters enabled by defining WB_ARB_STATS_EN.
//==============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int W = 8,
  parameter int A = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             AluValid,
  output logic             AluReady,
  input  logic [A-1:0]     AluAddr,
  input  logic [W-1:0]     AluData,
  input  logic             AluMov,
  input  logic             LdValid,
  output logic             LdReady,
  input  logic [A-1:0]     LdAddr,
  input  logic [W-1:0]     LdData,
  input  logic             IssueLd,
  input  logic [A-1:0]     IssueAddr,
  input  logic [A-1:0]     SrcA,
  input  logic [A-1:0]     SrcB,
  input  logic [A-1:0]     SrcC,
  input  logic [2:0]       SrcUse,
  output logic             Hazard,
  output logic [2**A-1:0]  Busy,
  output logic             WriteEn,
  output logic             MovEn,
  output logic [A-1:0]     Waddr,
  output logic [W-1:0]     DataIn
`ifdef WB_ARB_STATS_EN
  ,
  output logic [7:0]       ConflictCnt,
  output logic [7:0]       AluBlocked
`endif
);

  localparam int NREG = 2**A;

  typedef enum logic {
    PRI_LD  = 1'b0,
    PRI_ALU = 1'b1
  } pri_t;

  pri_t            pri_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            we_q;
  logic            mov_q;
  logic [A-1:0]    waddr_q;
  logic [W-1:0]    data_q;

  logic            alu_elig;
  logic            ld_elig;
  logic            both_elig;
  logic            alu_gnt;
  logic            ld_gnt;
  logic            in_flight;
  logic            hazard;

  // A source collides with a pending load or with the write still landing this cycle.
  function automatic logic src_hit(input logic use_i, input logic [A-1:0] src_i,
                                   input logic [NREG-1:0] busy_i, input logic fly_i,
                                   input logic [A-1:0] waddr_i);
    src_hit = use_i & (busy_i[src_i] | (fly_i & (waddr_i == src_i)));
  endfunction

  always_comb begin
    alu_elig  = AluValid & ~busy_q[AluAddr];
    ld_elig   = LdValid;
    both_elig = alu_elig & ld_elig;
    ld_gnt    = ~Reset & ld_elig  & (~alu_elig | (pri_q == PRI_LD));
    alu_gnt   = ~Reset & alu_elig & (~ld_elig  | (pri_q == PRI_ALU));
  end

  // Set beats clear when an issue and a load return hit the same register.
  always_comb begin
    busy_d = busy_q;
    if (ld_gnt) busy_d[LdAddr] = 1'b0;
    if (IssueLd) busy_d[IssueAddr] = 1'b1;
  end

  always_comb begin
    in_flight = we_q | mov_q;
    hazard    = IssueLd & busy_q[IssueAddr];
    hazard    = hazard | src_hit(SrcUse[0], SrcA, busy_q, in_flight, waddr_q);
    hazard    = hazard | src_hit(SrcUse[1], SrcB, busy_q, in_flight, waddr_q);
    hazard    = hazard | src_hit(SrcUse[2], SrcC, busy_q, in_flight, waddr_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pri_q   <= PRI_LD;
      busy_q  <= '0;
      we_q    <= 1'b0;
      mov_q   <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      busy_q <= busy_d;
      we_q   <= ld_gnt | (alu_gnt & ~AluMov);
      mov_q  <= alu_gnt & AluMov;
      if (ld_gnt) begin
        waddr_q <= LdAddr;
        data_q  <= LdData;
      end else if (alu_gnt) begin
        waddr_q <= AluAddr;
        data_q  <= AluData;
      end
      if (both_elig) begin
        pri_q <= (pri_q == PRI_LD) ? PRI_ALU : PRI_LD;
      end
    end
  end

  assign AluReady = alu_gnt;
  assign LdReady  = ld_gnt;
  assign Hazard   = hazard;
  assign Busy     = busy_q;
  assign WriteEn  = we_q;
  assign MovEn    = mov_q;
  assign Waddr    = waddr_q;
  assign DataIn   = data_q;

`ifdef WB_ARB_STATS_EN
  logic [7:0] conflict_q;
  logic [7:0] blocked_q;
  logic       alu_blk;

  assign alu_blk = AluValid & busy_q[AluAddr];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      conflict_q <= '0;
      blocked_q  <= '0;
    end else begin
      if (both_elig && (conflict_q != 8'hFF)) conflict_q <= conflict_q + 8'd1;
      if (alu_blk && (blocked_q != 8'hFF))    blocked_q  <= blocked_q + 8'd1;
    end
  end

  assign ConflictCnt = conflict_q;
  assign AluBlocked  = blocked_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//==============================================================================
// tb_regfile_wb_arbiter: directed stimulus, scoreboard model checked every cycle plus literal checks.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       AluValid = 1'b0, AluMov = 1'b0, LdValid = 1'b0, IssueLd = 1'b0;
  logic [1:0] AluAddr = '0, LdAddr = '0, IssueAddr = '0, SrcA = '0, SrcB = '0, SrcC = '0;
  logic [7:0] AluData = '0, LdData = '0;
  logic [2:0] SrcUse = '0;
  logic       AluReady, LdReady, Hazard, WriteEn, MovEn;
  logic [3:0] Busy;
  logic [1:0] Waddr;
  logic [7:0] DataIn;
`ifdef WB_ARB_STATS_EN
  logic [7:0] ConflictCnt, AluBlocked;
`endif

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.W(8), .A(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData), .AluMov(AluMov),
    .LdValid(LdValid), .LdReady(LdReady), .LdAddr(LdAddr), .LdData(LdData),
    .IssueLd(IssueLd), .IssueAddr(IssueAddr),
    .SrcA(SrcA), .SrcB(SrcB), .SrcC(SrcC), .SrcUse(SrcUse),
    .Hazard(Hazard), .Busy(Busy),
    .WriteEn(WriteEn), .MovEn(MovEn), .Waddr(Waddr), .DataIn(DataIn)
`ifdef WB_ARB_STATS_EN
    , .ConflictCnt(ConflictCnt), .AluBlocked(AluBlocked)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: state as seen after the most recent rising edge.
  bit       mvalid = 1'b0;
  bit [3:0] m_busy;
  bit       m_ld_turn;
  bit       m_we, m_mov;
  bit [1:0] m_addr;
  bit [7:0] m_data;
  int       m_cc, m_ab;

  always @(negedge Clk) begin
    bit       ae, le, win_ld, win_alu, hz, fly;
    bit [1:0] srcs [3];
    ae = AluValid && !m_busy[AluAddr];
    le = LdValid;
    win_ld = 1'b0;
    win_alu = 1'b0;
    if (!Reset) begin
      if (ae && le) begin
        win_ld  = m_ld_turn;
        win_alu = !m_ld_turn;
      end else begin
        win_ld  = le;
        win_alu = ae;
      end
    end
    srcs[0] = SrcA; srcs[1] = SrcB; srcs[2] = SrcC;
    fly = m_we || m_mov;
    hz  = IssueLd && m_busy[IssueAddr];
    for (int k = 0; k < 3; k++)
      if (SrcUse[k] && (m_busy[srcs[k]] || (fly && m_addr == srcs[k]))) hz = 1'b1;

    if (mvalid) begin
      chk("AluReady", 32'(AluReady), 32'(win_alu));
      chk("LdReady",  32'(LdReady),  32'(win_ld));
      chk("Hazard",   32'(Hazard),   32'(hz));
      chk("Busy",     32'(Busy),     32'(m_busy));
      chk("WriteEn",  32'(WriteEn),  32'(m_we));
      chk("MovEn",    32'(MovEn),    32'(m_mov));
      chk("Waddr",    32'(Waddr),    32'(m_addr));
      if (m_we)  chk("DataIn",     32'(DataIn),      32'(m_data));
      if (m_mov) chk("DataInNib",  32'(DataIn[3:0]), 32'(m_data[3:0]));
`ifdef WB_ARB_STATS_EN
      chk("ConflictCnt", 32'(ConflictCnt), 32'(m_cc));
      chk("AluBlocked",  32'(AluBlocked),  32'(m_ab));
`endif
    end

    if (Reset) begin
      mvalid = 1'b1;
      m_busy = '0; m_ld_turn = 1'b1; m_we = 1'b0; m_mov = 1'b0;
      m_addr = '0; m_data = '0; m_cc = 0; m_ab = 0;
    end else begin
      if (ae && le && m_cc < 255) m_cc++;
      if (AluValid && m_busy[AluAddr] && m_ab < 255) m_ab++;
      if (ae && le) m_ld_turn = !m_ld_turn;
      m_we  = win_ld || (win_alu && !AluMov);
      m_mov = win_alu && AluMov;
      if (win_ld) begin
        m_addr = LdAddr; m_data = LdData; m_busy[LdAddr] = 1'b0;
      end else if (win_alu) begin
        m_addr = AluAddr; m_data = AluData;
      end
      if (IssueLd) m_busy[IssueAddr] = 1'b1;
    end
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset with a pending ALU request
    AluValid = 1'b1;
    step; step;
    #3;
    chk("rst_AluReady", 32'(AluReady), 32'd0);
    chk("rst_WriteEn",  32'(WriteEn),  32'd0);
    chk("rst_Busy",     32'(Busy),     32'd0);
    step; Reset = 1'b0;
    #3 chk("rel_AluReady", 32'(AluReady), 32'd1);
    step; AluValid = 1'b0;
    #3 chk("rel_WriteEn", 32'(WriteEn), 32'd1);

    // Plain ALU write
    step; AluValid = 1'b1; AluAddr = 2'd2; AluData = 8'h5A; AluMov = 1'b0;
    step; AluValid = 1'b0;
    #3;
    chk("alu_WriteEn", 32'(WriteEn), 32'd1);
    chk("alu_MovEn",   32'(MovEn),   32'd0);
    chk("alu_Waddr",   32'(Waddr),   32'd2);
    chk("alu_DataIn",  32'(DataIn),  32'h5A);

    // Both requesters from reset: LD, ALU, LD, ALU
    step; Reset = 1'b1;
    LdValid = 1'b1; LdAddr = 2'd1; LdData = 8'h11;
    AluValid = 1'b1; AluAddr = 2'd2; AluData = 8'h22;
    step; Reset = 1'b0;
    #3;
    chk("rr0_LdReady",  32'(LdReady),  32'd1);
    chk("rr0_AluReady", 32'(AluReady), 32'd0);
    step; #3;
    chk("rr1_AluReady", 32'(AluReady), 32'd1);
    chk("rr1_DataIn",   32'(DataIn),   32'h11);
    step; #3;
    chk("rr2_LdReady",  32'(LdReady),  32'd1);
    chk("rr2_DataIn",   32'(DataIn),   32'h22);
    step; #3;
    chk("rr3_AluReady", 32'(AluReady), 32'd1);
    chk("rr3_Waddr",    32'(Waddr),    32'd1);
    step; LdValid = 1'b0; AluValid = 1'b0;
    #3;
    chk("rr4_WriteEn", 32'(WriteEn), 32'd1);
    chk("rr4_Waddr",   32'(Waddr),   32'd2);
`ifdef WB_ARB_STATS_EN
    chk("rr4_ConflictCnt", 32'(ConflictCnt), 32'd4);
`endif
    step; #3 chk("idle_WriteEn", 32'(WriteEn), 32'd0);

    // Load issue to R1 raises a RAW hazard until its writeback has landed
    step; IssueLd = 1'b1; IssueAddr = 2'd1; SrcA = 2'd1; SrcUse = 3'b001;
    step; IssueLd = 1'b0;
    #3;
    chk("ld_Busy",   32'(Busy),   32'b0010);
    chk("ld_Hazard", 32'(Hazard), 32'd1);
    step; LdValid = 1'b1; LdAddr = 2'd1; LdData = 8'h33;
    #3 chk("ld_LdReady", 32'(LdReady), 32'd1);
    step; LdValid = 1'b0;
    #3;
    chk("ldwb_WriteEn", 32'(WriteEn), 32'd1);
    chk("ldwb_DataIn",  32'(DataIn),  32'h33);
    chk("ldwb_Busy",    32'(Busy),    32'd0);
    chk("ldwb_Hazard",  32'(Hazard),  32'd1);
    step; #3 chk("ldwb_HazardDrop", 32'(Hazard), 32'd0);

    // WAW: ALU write to R3 waits behind the load to R3
    step; SrcUse = 3'b000; IssueLd = 1'b1; IssueAddr = 2'd3;
    step; IssueLd = 1'b0; AluValid = 1'b1; AluAddr = 2'd3; AluData = 8'h77;
    #3;
    chk("waw_Busy",     32'(Busy),     32'b1000);
    chk("waw_AluReady", 32'(AluReady), 32'd0);
    step; #3 chk("waw_AluReady2", 32'(AluReady), 32'd0);
    step; LdValid = 1'b1; LdAddr = 2'd3; LdData = 8'h44;
    #3;
    chk("waw_LdReady",   32'(LdReady),  32'd1);
    chk("waw_AluReady3", 32'(AluReady), 32'd0);
    step; LdValid = 1'b0;
    #3;
    chk("waw_AluGo",   32'(AluReady), 32'd1);
    chk("waw_LdWrite", 32'(DataIn),   32'h44);
    step; AluValid = 1'b0;
    #3;
    chk("waw_AluWrite", 32'(DataIn), 32'h77);
    chk("waw_Waddr",    32'(Waddr),  32'd3);
`ifdef WB_ARB_STATS_EN
    chk("waw_AluBlocked", 32'(AluBlocked), 32'd3);
`endif

    // Nibble MOV
    step; AluValid = 1'b1; AluMov = 1'b1; AluData = 8'h0B; AluAddr = 2'd0;
    step; AluValid = 1'b0; AluMov = 1'b0;
    #3;
    chk("mov_MovEn",   32'(MovEn),       32'd1);
    chk("mov_WriteEn", 32'(WriteEn),     32'd0);
    chk("mov_Nibble",  32'(DataIn[3:0]), 32'hB);

    // Issue and load return to the same register in one cycle: set wins
    step; IssueLd = 1'b1; IssueAddr = 2'd2; LdValid = 1'b1; LdAddr = 2'd2; LdData = 8'h55;
    step; IssueLd = 1'b0; LdValid = 1'b0;
    #3;
    chk("setwin_Busy",   32'(Busy),   32'b0100);
    chk("setwin_DataIn", 32'(DataIn), 32'h55);
    step; LdValid = 1'b1; LdData = 8'h66;
    step; LdValid = 1'b0;
    #3 chk("clr_Busy", 32'(Busy), 32'd0);

    // Reset in the middle of a handshake: nothing written
    step; AluValid = 1'b1; AluAddr = 2'd1; AluData = 8'h99; Reset = 1'b1;
    step; Reset = 1'b0; AluValid = 1'b0;
    #3 chk("midrst_WriteEn", 32'(WriteEn), 32'd0);

    step; step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
